// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared state, status and opcode definitions for the brainfuck run controller and core
//
// Contents:
//   run_state_e   run controller FSM states
//   STATUS_*      job result codes reported on bf_run_ctrl.status
//   OP_*          program opcodes; OP_END terminates a program in program RAM
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_TERM  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } run_state_e;

    // Code 1 is not produced by this controller.
    localparam logic [1:0] STATUS_HALTED   = 2'd0;
    localparam logic [1:0] STATUS_WATCHDOG = 2'd2;
    localparam logic [1:0] STATUS_OVERFLOW = 2'd3;

    localparam logic [7:0] OP_RIGHT      = 8'h3E;  // '>'
    localparam logic [7:0] OP_LEFT       = 8'h3C;  // '<'
    localparam logic [7:0] OP_INC        = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC        = 8'h2D;  // '-'
    localparam logic [7:0] OP_OUT        = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN         = 8'h2C;  // ','
    localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;  // ']'
    localparam logic [7:0] OP_END        = 8'h00;

endpackage

// File: rtl/bf_byte_buf.sv
// rtl/bf_byte_buf.sv - one-entry valid/ready byte register with capture and drain
//
// Ports:
//   clk, reset         clock, synchronous active-high reset (empties the buffer, data -> 0)
//   capture            load capture_data this cycle; caller only asserts it when it may overwrite
//   capture_data[7:0]  byte to store
//   out_ready          downstream accepts out_data when out_valid
//   out_valid          buffer holds a byte
//   out_data[7:0]      held byte (kept after drain)
module bf_byte_buf
    import bf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic [7:0] capture_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    logic       valid_q, valid_d;
    logic [7:0] data_q,  data_d;

    // Capture wins over a same-cycle drain: the old byte leaves, the new one stays.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            valid_d = 1'b1;
            data_d  = capture_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= OP_END;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/bf_run_ctrl.sv
// rtl/bf_run_ctrl.sv - job sequencer: clear data RAM, load program, run core, stream output, detect halt
//
// Optional feature macro: BF_RUN_CTRL_WATCHDOG_EN (RUN-cycle watchdog, status 2 at MAX_CYCLES).
//
// Ports:
//   clk, reset                                 clock, synchronous active-high reset
//   start                                      job request (honoured in IDLE and DONE)
//   load_valid/load_ready/load_data/load_last  program byte stream in
//   out_valid/out_ready/out_data               program output byte stream
//   busy, done, status[1:0]                    job progress and result
//   core_en, core_reset                        core control
//   core_prog_ren                              core program fetch strobe (halt detection)
//   core_stdout, core_stdout_en                core output byte and strobe
//   core_data_addr/wen/wval                    core data RAM request (forwarded in RUN)
//   prog_we/prog_waddr/prog_wdata              program RAM write port (registered)
//   dmem_addr/dmem_wen/dmem_wval               data RAM port (clear engine or core)
module bf_run_ctrl
    import bf_pkg::*;
#(
    parameter int DATA_ADDR_WIDTH = 8,
    parameter int PROG_ADDR_WIDTH = 8,
    parameter int HALT_IDLE       = 8,
    parameter int MAX_CYCLES      = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [7:0]                 load_data,
    input  logic                       load_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 status,
    output logic                       core_en,
    output logic                       core_reset,
    input  logic                       core_prog_ren,
    input  logic [7:0]                 core_stdout,
    input  logic                       core_stdout_en,
    input  logic [DATA_ADDR_WIDTH-1:0] core_data_addr,
    input  logic                       core_data_wen,
    input  logic [7:0]                 core_data_wval,
    output logic                       prog_we,
    output logic [PROG_ADDR_WIDTH-1:0] prog_waddr,
    output logic [7:0]                 prog_wdata,
    output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
    output logic                       dmem_wen,
    output logic [7:0]                 dmem_wval
);

    localparam int DW     = DATA_ADDR_WIDTH;
    localparam int PW     = PROG_ADDR_WIDTH;
    localparam int HALT_W = $clog2(HALT_IDLE + 1);

    // Last address a non-final byte may occupy; the top cell is kept for the terminator.
    localparam logic [PW-1:0] PROG_LIMIT = {{(PW-1){1'b1}}, 1'b0};

    run_state_e        state_q, state_d;
    logic [DW-1:0]     clr_addr_q, clr_addr_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [HALT_W-1:0] halt_cnt_q, halt_cnt_d;
    logic [1:0]        status_q, status_d;
    logic              prog_we_q, prog_we_d;
    logic [PW-1:0]     prog_waddr_q, prog_waddr_d;
    logic [7:0]        prog_wdata_q, prog_wdata_d;

    logic load_fire;
    logic run_en;
    logic capture;
    logic halt_fire;
    logic wd_fire;

    assign load_fire = load_valid && load_ready;
    assign run_en    = (state_q == ST_RUN) && core_en;
    // core_en is already low while a strobe waits on a full buffer, so a stalled
    // strobe is captured exactly once: in the first cycle the buffer is free.
    assign capture   = run_en && core_stdout_en;

    //------------------------------------------------------------------
    // Halt detection: enabled cycles since the last program fetch.
    //------------------------------------------------------------------
    always_comb begin
        halt_cnt_d = halt_cnt_q;
        if (state_q != ST_RUN) begin
            halt_cnt_d = '0;
        end else if (core_prog_ren) begin
            halt_cnt_d = '0;
        end else if (core_en) begin
            halt_cnt_d = halt_cnt_q + HALT_W'(1);
        end
    end

    // The count is always below HALT_IDLE while in RUN, so equality here
    // means this cycle's increment reached the limit.
    assign halt_fire = (state_q == ST_RUN) && (halt_cnt_d == HALT_W'(HALT_IDLE));

`ifdef BF_RUN_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_TERM) begin
            wd_cnt_d = '0;
        end else if (run_en && (wd_cnt_q != '1)) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
    end

    assign wd_fire = run_en && (wd_cnt_d == 32'(MAX_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic [31:0] wd_limit_unused;
    assign wd_limit_unused = 32'(MAX_CYCLES);
    assign wd_fire         = 1'b0;
`endif

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_addr_q == '1) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_fire) begin
                    if (load_last) begin
                        state_d = ST_TERM;
                    end else if (ptr_q == PROG_LIMIT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_TERM: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_fire || wd_fire) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        core_en    = 1'b1;
        core_reset = 1'b1;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dmem_addr  = '0;
        dmem_wen   = 1'b0;
        dmem_wval  = 8'h00;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                dmem_addr = clr_addr_q;
                dmem_wen  = 1'b1;
                dmem_wval = 8'h00;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
            end
            ST_TERM: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                busy       = 1'b1;
                core_reset = 1'b0;
                core_en    = !(core_stdout_en && out_valid);
                dmem_addr  = core_data_addr;
                dmem_wen   = core_data_wen;
                dmem_wval  = core_data_wval;
            end
            ST_DONE: begin
                core_en    = 1'b0;
                // An overflowed job never ran the core; keep it in reset.
                core_reset = (status_q == STATUS_OVERFLOW);
                done       = !out_valid;
            end
            default: begin
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath: clear address, load pointer, program write port, status
    //------------------------------------------------------------------
    always_comb begin
        clr_addr_d   = (state_q == ST_CLEAR) ? clr_addr_q + DW'(1) : '0;
        ptr_d        = ptr_q;
        prog_we_d    = 1'b0;
        prog_waddr_d = prog_waddr_q;
        prog_wdata_d = prog_wdata_q;
        status_d     = status_q;

        if (state_q == ST_CLEAR) begin
            ptr_d = '0;
        end else if (load_fire) begin
            ptr_d        = ptr_q + PW'(1);
            prog_we_d    = 1'b1;
            prog_waddr_d = ptr_q;
            prog_wdata_d = load_data;
        end else if (state_q == ST_TERM) begin
            // Lands in the first RUN cycle; the core fetches address 0 first
            // and ptr is at least 1 here, so the fetch never races this write.
            prog_we_d    = 1'b1;
            prog_waddr_d = ptr_q;
            prog_wdata_d = OP_END;
        end

        if (state_d == ST_CLEAR) begin
            status_d = STATUS_HALTED;
        end else if ((state_q == ST_LOAD) && (state_d == ST_DONE)) begin
            status_d = STATUS_OVERFLOW;
        end else if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
            status_d = halt_fire ? STATUS_HALTED : STATUS_WATCHDOG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr_q   <= '0;
            ptr_q        <= '0;
            halt_cnt_q   <= '0;
            status_q     <= STATUS_HALTED;
            prog_we_q    <= 1'b0;
            prog_waddr_q <= '0;
            prog_wdata_q <= 8'h00;
        end else begin
            clr_addr_q   <= clr_addr_d;
            ptr_q        <= ptr_d;
            halt_cnt_q   <= halt_cnt_d;
            status_q     <= status_d;
            prog_we_q    <= prog_we_d;
            prog_waddr_q <= prog_waddr_d;
            prog_wdata_q <= prog_wdata_d;
        end
    end

    assign status     = status_q;
    assign prog_we    = prog_we_q;
    assign prog_waddr = prog_waddr_q;
    assign prog_wdata = prog_wdata_q;

    bf_byte_buf u_out_buf (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .capture_data (core_stdout),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data)
    );

endmodule

// File: tb/tb_bf_run_ctrl.sv
// tb/tb_bf_run_ctrl.sv - directed, table-driven bench for bf_run_ctrl
module tb_bf_run_ctrl;
    import bf_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic       core_en;
    logic       core_reset;
    logic       core_prog_ren;
    logic [7:0] core_stdout;
    logic       core_stdout_en;
    logic [7:0] core_data_addr;
    logic       core_data_wen;
    logic [7:0] core_data_wval;
    logic       prog_we;
    logic [3:0] prog_waddr;
    logic [7:0] prog_wdata;
    logic [7:0] dmem_addr;
    logic       dmem_wen;
    logic [7:0] dmem_wval;

    int checks = 0;
    int errors = 0;

    bf_run_ctrl #(
        .DATA_ADDR_WIDTH (8),
        .PROG_ADDR_WIDTH (4),
        .HALT_IDLE       (8),
        .MAX_CYCLES      (1000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_last      (load_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .core_en        (core_en),
        .core_reset     (core_reset),
        .core_prog_ren  (core_prog_ren),
        .core_stdout    (core_stdout),
        .core_stdout_en (core_stdout_en),
        .core_data_addr (core_data_addr),
        .core_data_wen  (core_data_wen),
        .core_data_wval (core_data_wval),
        .prog_we        (prog_we),
        .prog_waddr     (prog_waddr),
        .prog_wdata     (prog_wdata),
        .dmem_addr      (dmem_addr),
        .dmem_wen       (dmem_wen),
        .dmem_wval      (dmem_wval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    // One RUN/DONE cycle: core-side stimulus and expected controller outputs.
    typedef struct {
        logic       ren;
        logic       sen;
        logic [7:0] sd;
        logic       ordy;
        logic       en;
        logic       crst;
        logic       ov;
        logic [7:0] od;
        logic       busy;
        logic       done;
        logic       run;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] prog[$];

    function automatic void add(input logic ren, input logic sen, input logic [7:0] sd,
                                input logic ordy, input logic en, input logic crst,
                                input logic ov, input logic [7:0] od, input logic bsy,
                                input logic dn, input logic run);
        vec_t v;
        v.ren = ren; v.sen = sen; v.sd = sd; v.ordy = ordy;
        v.en = en; v.crst = crst; v.ov = ov; v.od = od;
        v.busy = bsy; v.done = dn; v.run = run;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int idx);
        check("reset_vals", idx,
              64'({load_ready, out_valid, out_data, busy, done, status, prog_we, dmem_wen,
                   prog_waddr, dmem_addr, dmem_wval, prog_wdata, core_en, core_reset}),
              64'h3);
    endtask

    task automatic start_job(input int job);
        int wr;
        int ok;
        int n;
        wr = 0; ok = 0; n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        check("status_cleared", job, 64'(status), 64'(STATUS_HALTED));
        while (!load_ready && n < 400) begin
            if (dmem_wen) begin
                if (dmem_addr == 8'(wr) && dmem_wval == 8'h00 && busy && core_reset) ok++;
                wr++;
            end
            @(negedge clk); #1;
            n++;
        end
        check("clear_writes", job, 64'(wr), 64'(256));
        check("clear_order", job, 64'(ok), 64'(256));
    endtask

    // Streams prog[] into LOAD; returns at the negedge after the final accepted byte.
    task automatic load_prog(input bit with_last, output int acc);
        int w;
        acc = 0;
        for (int i = 0; i < prog.size(); i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = with_last && (i == prog.size() - 1);
            #1;
            w = 0;
            while (!load_ready && w < 20) begin
                @(negedge clk); #1;
                w++;
            end
            if (!load_ready) break;
            @(negedge clk);
            acc++;
            check("prog_write", i, 64'({prog_we, prog_waddr, prog_wdata}),
                  64'({1'b1, 4'(i), prog[i]}));
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_term(input int job);
        #1;
        check("term_state", job, 64'({load_ready, busy, core_reset, core_en}), 64'(4'b0111));
    endtask

    task automatic run_vecs(input int lo, input int hi, input int term_addr);
        logic [7:0] ea;
        logic       ew;
        logic [7:0] ev;
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            core_prog_ren  = vecs[i].ren;
            core_stdout_en = vecs[i].sen;
            core_stdout    = vecs[i].sd;
            out_ready      = vecs[i].ordy;
            core_data_addr = 8'(i);
            core_data_wen  = i[0];
            core_data_wval = 8'(i * 3 + 1);
            #1;
            if (i == lo) begin
                check("term_write", i, 64'({prog_we, prog_waddr, prog_wdata}),
                      64'({1'b1, 4'(term_addr), OP_END}));
            end
            check("vec", i, 64'({core_en, core_reset, out_valid, out_data, busy, done}),
                  64'({vecs[i].en, vecs[i].crst, vecs[i].ov, vecs[i].od,
                       vecs[i].busy, vecs[i].done}));
            ea = vecs[i].run ? 8'(i) : 8'h00;
            ew = vecs[i].run ? i[0] : 1'b0;
            ev = vecs[i].run ? 8'(i * 3 + 1) : 8'h00;
            check("dmem_mux", i, 64'({dmem_addr, dmem_wen, dmem_wval}), 64'({ea, ew, ev}));
        end
        core_prog_ren  = 1'b0;
        core_stdout_en = 1'b0;
        core_stdout    = 8'h00;
        core_data_addr = 8'h00;
        core_data_wen  = 1'b0;
        core_data_wval = 8'h00;
    endtask

    initial begin
        int s1_lo, s1_hi, s2_lo, s2_hi, s3_lo, s3_hi;
        int acc;
        int n;
        int run_cycles;

        // Job 1, "+.": one byte 0x01 drained immediately, halt 8 enabled cycles later.
        s1_lo = vecs.size();
        add(1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 0, 1);
        add(1, 0, 8'h00, 1,  1, 0, 0, 8'h00, 1, 0, 1);
        add(1, 1, 8'h01, 1,  1, 0, 0, 8'h00, 1, 0, 1);
        add(0, 0, 8'h00, 1,  1, 0, 1, 8'h01, 1, 0, 1);
        for (int k = 0; k < 7; k++) add(0, 0, 8'h00, 1,  1, 0, 0, 8'h01, 1, 0, 1);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'h01, 0, 1, 0);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'h01, 0, 1, 0);
        s1_hi = vecs.size();

        // Job 2, "+.+.+.": second strobe stalls against a full buffer; stalled
        // cycles must neither re-capture nor advance the halt count.
        s2_lo = vecs.size();
        add(1, 0, 8'h00, 0,  1, 0, 0, 8'h01, 1, 0, 1);
        add(1, 1, 8'h01, 0,  1, 0, 0, 8'h01, 1, 0, 1);
        add(1, 0, 8'h00, 0,  1, 0, 1, 8'h01, 1, 0, 1);
        add(1, 1, 8'h02, 0,  0, 0, 1, 8'h01, 1, 0, 1);
        for (int k = 0; k < 7; k++) add(0, 1, 8'h02, 0,  0, 0, 1, 8'h01, 1, 0, 1);
        add(0, 1, 8'h02, 1,  0, 0, 1, 8'h01, 1, 0, 1);
        add(0, 1, 8'h02, 0,  1, 0, 0, 8'h01, 1, 0, 1);
        add(1, 0, 8'h00, 1,  1, 0, 1, 8'h02, 1, 0, 1);
        add(1, 1, 8'h03, 1,  1, 0, 0, 8'h02, 1, 0, 1);
        add(0, 0, 8'h00, 1,  1, 0, 1, 8'h03, 1, 0, 1);
        for (int k = 0; k < 7; k++) add(0, 0, 8'h00, 1,  1, 0, 0, 8'h03, 1, 0, 1);
        add(0, 0, 8'h00, 1,  0, 0, 0, 8'h03, 0, 1, 0);
        s2_hi = vecs.size();

        // Job 3, "+++[-].": byte 0x00 still pending at halt -> DONE-pending until drained.
        s3_lo = vecs.size();
        add(1, 0, 8'h00, 0,  1, 0, 0, 8'h00, 1, 0, 1);
        add(1, 1, 8'h00, 0,  1, 0, 0, 8'h00, 1, 0, 1);
        for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 0,  1, 0, 1, 8'h00, 1, 0, 1);
        add(0, 0, 8'h00, 0,  0, 0, 1, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 1,  0, 0, 1, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1, 0);
        s3_hi = vecs.size();

        reset = 1'b1; start = 1'b0;
        load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        out_ready = 1'b0;
        core_prog_ren = 1'b0; core_stdout = 8'h00; core_stdout_en = 1'b0;
        core_data_addr = 8'h00; core_data_wen = 1'b0; core_data_wval = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals(0);

        start_job(1);
        prog = {OP_INC, OP_OUT};
        load_prog(1'b1, acc);
        check_term(1);
        run_vecs(s1_lo, s1_hi, 2);
        check("status_job1", 1, 64'(status), 64'(STATUS_HALTED));

        start_job(2);
        prog = {OP_INC, OP_OUT, OP_INC, OP_OUT, OP_INC, OP_OUT};
        load_prog(1'b1, acc);
        check_term(2);
        run_vecs(s2_lo, s2_hi, 6);
        check("status_job2", 2, 64'(status), 64'(STATUS_HALTED));

        // Reset mid-LOAD, after a start pulse that LOAD must ignore.
        start_job(3);
        prog = {OP_INC, OP_INC, OP_INC};
        load_prog(1'b0, acc);
        check("partial_load", 3, 64'(acc), 64'(3));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_ignored", 3, 64'({load_ready, busy}), 64'(2'b11));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals(1);

        start_job(4);
        prog = {OP_INC, OP_INC, OP_INC, OP_LOOP_OPEN, OP_DEC, OP_LOOP_CLOSE, OP_OUT};
        load_prog(1'b1, acc);
        check_term(4);
        run_vecs(s3_lo, s3_hi, 7);
        check("status_job4", 4, 64'(status), 64'(STATUS_HALTED));

        // Overflow: 16 bytes offered to a 16-cell program RAM, no load_last.
        start_job(5);
        prog.delete();
        for (int k = 0; k < 16; k++) prog.push_back(OP_INC);
        load_prog(1'b0, acc);
        check("ovf_accepted", 5, 64'(acc), 64'(15));
        #1;
        check("ovf_state", 5, 64'({status, load_ready, core_reset, core_en, done, busy}),
              64'({STATUS_OVERFLOW, 5'b01010}));

        // A new job from an overflowed DONE must clear the status.
        start_job(6);

`ifdef BF_RUN_CTRL_WATCHDOG_EN
        prog = {OP_INC, OP_LOOP_OPEN, OP_LOOP_CLOSE};
        load_prog(1'b1, acc);
        check_term(6);
        core_prog_ren = 1'b1;
        out_ready = 1'b1;
        n = 0;
        run_cycles = 0;
        while (!done && n < 1200) begin
            @(negedge clk); #1;
            if (busy && !core_reset && core_en) run_cycles++;
            n++;
        end
        core_prog_ren = 1'b0;
        check("wd_cycles", 6, 64'(run_cycles), 64'(1000));
        check("wd_status", 6, 64'(status), 64'(STATUS_WATCHDOG));
`else
        n = 0;
        run_cycles = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
